// File: rtl/wave_voice_sched.sv
`default_nettype none
// ============================================================================
// Module   : wave_voice_sched
// Brief    : Shares one triangle generator across NUM_VOICES phase accumulators
//            and mixes the enabled voice levels once per sample_tick.
//            Optional macro VOICE_ATTEN_EN adds per-voice shift attenuation.
// Revision : 1.0 - initial release
// ============================================================================
module wave_voice_sched #(
    parameter int NUM_VOICES = 4,
    parameter int ACC_W      = 16,
    parameter int MIX_W      = 7 + $clog2(NUM_VOICES)
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          sample_tick,
    input  logic                          cfg_we,
    input  logic [$clog2(NUM_VOICES)-1:0] cfg_addr,
    input  logic [ACC_W-1:0]              cfg_inc,
    input  logic                          cfg_en,
    input  logic                          cfg_phase_clr,
`ifdef VOICE_ATTEN_EN
    input  logic [1:0]                    cfg_shift,
`endif
    output logic [7:0]                    wave_phase,
    input  logic [6:0]                    wave_level,
    output logic [MIX_W-1:0]              mix_out,
    output logic                          mix_valid,
    output logic                          busy,
    output logic                          overrun
);

    localparam int c_aw    = $clog2(NUM_VOICES);
    localparam int c_cnt_w = $clog2(NUM_VOICES + 2);

    localparam logic [1:0] c_idle  = 2'd0;
    localparam logic [1:0] c_issue = 2'd1;
    localparam logic [1:0] c_drain = 2'd2;
    localparam logic [1:0] c_done  = 2'd3;

    // r_cnt is the cycle number inside a scan: voice n is issued in cycle n
    // and captured in cycle n+2, so the last capture lands in NUM_VOICES+1.
    localparam logic [c_cnt_w-1:0] c_last_issue = c_cnt_w'(NUM_VOICES - 1);
    localparam logic [c_cnt_w-1:0] c_last_cap   = c_cnt_w'(NUM_VOICES + 1);

    logic [1:0]          r_state;
    logic [1:0]          w_state_next;
    logic [c_cnt_w-1:0]  r_cnt;
    logic [ACC_W-1:0]    r_phase [NUM_VOICES];
    logic [ACC_W-1:0]    r_inc   [NUM_VOICES];
    logic [NUM_VOICES-1:0] r_en;
    logic [MIX_W-1:0]    r_sum;

    logic                w_start;
    logic                w_issue;
    logic                w_capture;
    logic                w_last_cap;
    logic                w_cfg_hit;
    logic [c_aw-1:0]     w_iss_idx;
    logic [c_aw-1:0]     w_cap_idx;
    logic [6:0]          w_level_att;
    logic [MIX_W-1:0]    w_contrib;
    logic [MIX_W-1:0]    w_sum_next;

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= c_idle;
        end else begin
            r_state <= w_state_next;
        end
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            c_idle:  if (sample_tick)            w_state_next = c_issue;
            c_issue: if (r_cnt == c_last_issue)  w_state_next = c_drain;
            c_drain: if (r_cnt == c_last_cap)    w_state_next = c_done;
            default:                             w_state_next = c_idle;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        busy      = (r_state != c_idle);
        mix_valid = (r_state == c_done);
    end

    assign w_start    = (r_state == c_idle) && sample_tick;
    assign w_issue    = (r_state == c_issue);
    assign w_capture  = ((r_state == c_issue) || (r_state == c_drain)) &&
                        (r_cnt >= c_cnt_w'(2));
    assign w_last_cap = (r_state == c_drain) && (r_cnt == c_last_cap);
    assign w_iss_idx  = c_aw'(r_cnt);
    assign w_cap_idx  = c_aw'(r_cnt - c_cnt_w'(2));

`ifdef VOICE_ATTEN_EN
    logic [1:0] r_shift [NUM_VOICES];
    assign w_level_att = wave_level >> r_shift[w_cap_idx];
`else
    assign w_level_att = wave_level;
`endif

    assign w_contrib  = r_en[w_cap_idx] ? MIX_W'(w_level_att) : '0;
    assign w_sum_next = r_sum + w_contrib;

    // Out-of-range addresses only exist when NUM_VOICES is not a power of two.
    generate
        if ((1 << c_aw) == NUM_VOICES) begin : g_addr_full
            assign w_cfg_hit = cfg_we;
        end else begin : g_addr_partial
            assign w_cfg_hit = cfg_we && (32'(cfg_addr) < 32'(NUM_VOICES));
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int v = 0; v < NUM_VOICES; v++) begin
                r_phase[v] <= '0;
                r_inc[v]   <= '0;
`ifdef VOICE_ATTEN_EN
                r_shift[v] <= '0;
`endif
            end
            r_en       <= '0;
            r_cnt      <= '0;
            r_sum      <= '0;
            wave_phase <= '0;
            mix_out    <= '0;
            overrun    <= 1'b0;
        end else begin
            if (sample_tick && busy) begin
                overrun <= 1'b1;
            end

            if (w_start) begin
                r_cnt      <= c_cnt_w'(1);
                r_sum      <= '0;
                wave_phase <= r_phase[0][ACC_W-1 -: 8];
            end else if (w_issue || (r_state == c_drain)) begin
                r_cnt <= r_cnt + c_cnt_w'(1);
            end

            if (w_issue) begin
                wave_phase <= r_phase[w_iss_idx][ACC_W-1 -: 8];
            end
            if (w_capture) begin
                r_sum <= w_sum_next;
            end
            if (w_last_cap) begin
                mix_out <= w_sum_next;
            end

            // Config write is placed after the phase advance so a phase clear
            // on the capture edge wins; the advance itself uses the old inc.
            for (int v = 0; v < NUM_VOICES; v++) begin
                if (w_capture && (w_cap_idx == c_aw'(v)) && r_en[v]) begin
                    r_phase[v] <= r_phase[v] + r_inc[v];
                end
                if (w_cfg_hit && (cfg_addr == c_aw'(v))) begin
                    r_inc[v] <= cfg_inc;
                    r_en[v]  <= cfg_en;
`ifdef VOICE_ATTEN_EN
                    r_shift[v] <= cfg_shift;
`endif
                    if (cfg_phase_clr) begin
                        r_phase[v] <= '0;
                    end
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_wave_voice_sched.sv
`default_nettype none
// ============================================================================
// Module   : tb_wave_voice_sched
// Brief    : Self-checking bench for wave_voice_sched with a registered
//            triangle generator model and a voice-level mixing model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_wave_voice_sched;

    localparam int NV = 4;

    typedef struct {
        int addr;
        int inc;
        bit en;
        bit clr;
        int exp_mix;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        sample_tick = 1'b0;
    logic        cfg_we = 1'b0;
    logic [1:0]  cfg_addr = '0;
    logic [15:0] cfg_inc = '0;
    logic        cfg_en = 1'b0;
    logic        cfg_phase_clr = 1'b0;
`ifdef VOICE_ATTEN_EN
    logic [1:0]  cfg_shift = '0;
`endif
    logic [7:0]  wave_phase;
    logic [6:0]  wave_level;
    logic [8:0]  mix_out;
    logic        mix_valid;
    logic        busy;
    logic        overrun;

    int n_checks = 0;
    int n_fail   = 0;

    int m_phase [NV];
    int m_inc   [NV];
    int m_shift [NV];
    bit m_en    [NV];

    always #5 clk = ~clk;

    // Shared generator: one-cycle registered triangle.
    always_ff @(posedge clk) begin
        wave_level <= (wave_phase < 8'd128) ? wave_phase[6:0] : ~wave_phase[6:0];
    end

    wave_voice_sched #(.NUM_VOICES(NV), .ACC_W(16), .MIX_W(9)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .sample_tick   (sample_tick),
        .cfg_we        (cfg_we),
        .cfg_addr      (cfg_addr),
        .cfg_inc       (cfg_inc),
        .cfg_en        (cfg_en),
        .cfg_phase_clr (cfg_phase_clr),
`ifdef VOICE_ATTEN_EN
        .cfg_shift     (cfg_shift),
`endif
        .wave_phase    (wave_phase),
        .wave_level    (wave_level),
        .mix_out       (mix_out),
        .mix_valid     (mix_valid),
        .busy          (busy),
        .overrun       (overrun)
    );

    task automatic check(input string name, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, got, exp);
        end
    endtask

    function automatic int tri_level(input int acc);
        int p;
        p = (acc >> 8) & 255;
        return (p < 128) ? p : 255 - p;
    endfunction

    function automatic int model_scan();
        int s;
        s = 0;
        for (int v = 0; v < NV; v++) begin
            if (m_en[v]) begin
                s += tri_level(m_phase[v]) >> m_shift[v];
                m_phase[v] = (m_phase[v] + m_inc[v]) & 16'hFFFF;
            end
        end
        return s;
    endfunction

    // All driving tasks start and end on a falling edge.
    task automatic do_reset();
        rst_n = 1'b0;
        sample_tick = 1'b0;
        cfg_we = 1'b0;
        cfg_phase_clr = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        for (int v = 0; v < NV; v++) begin
            m_phase[v] = 0; m_inc[v] = 0; m_shift[v] = 0; m_en[v] = 1'b0;
        end
    endtask

    task automatic cfg_write(input int a, input int inc, input bit en, input bit clr, input int sh);
        cfg_we = 1'b1;
        cfg_addr = a[1:0];
        cfg_inc = inc[15:0];
        cfg_en = en;
        cfg_phase_clr = clr;
`ifdef VOICE_ATTEN_EN
        cfg_shift = sh[1:0];
        m_shift[a] = sh & 3;
`else
        m_shift[a] = 0 * sh;
`endif
        @(negedge clk);
        cfg_we = 1'b0;
        cfg_phase_clr = 1'b0;
        m_inc[a] = inc & 16'hFFFF;
        m_en[a] = en;
        if (clr) m_phase[a] = 0;
    endtask

    // lat = cycle (counted from the tick edge) in which mix_valid was seen, -1 on timeout.
    task automatic do_tick(output int lat, output int mix);
        sample_tick = 1'b1;
        @(negedge clk);
        sample_tick = 1'b0;
        lat = 1;
        while (!mix_valid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        mix = mix_out;
        if (!mix_valid) lat = -1;
        @(negedge clk);
    endtask

    task automatic wait_valid(inout int lat);
        while (!mix_valid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        if (!mix_valid) lat = -1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout, expected end of test");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int lat, mix, exp, cnt;
        vec_t tbl [8];

        tbl[0] = '{0, 'h0100, 1'b1, 1'b0, 0};
        tbl[1] = '{1, 'h0500, 1'b1, 1'b0, 1};
        tbl[2] = '{2, 'h9000, 1'b1, 1'b0, 7};
        tbl[3] = '{3, 'h0000, 1'b0, 1'b0, 124};
        tbl[4] = '{1, 'h0500, 1'b0, 1'b0, 36};
        tbl[5] = '{2, 'h9000, 1'b1, 1'b1, 5};
        tbl[6] = '{1, 'h0500, 1'b1, 1'b0, 132};
        tbl[7] = '{0, 'h0100, 1'b0, 1'b0, 52};

        do_reset();
        check("reset_mix_out", mix_out, 0);
        check("reset_mix_valid", mix_valid, 0);
        check("reset_busy", busy, 0);
        check("reset_overrun", overrun, 0);
        check("reset_wave_phase", wave_phase, 0);

        do_tick(lat, mix);
        check("idle_scan_latency", lat, 6);
        check("idle_scan_mix", mix, 0);
        check("idle_scan_phase", wave_phase, 0);
        check("idle_scan_busy_after", busy, 0);

        for (int i = 0; i < 8; i++) begin
            cfg_write(tbl[i].addr, tbl[i].inc, tbl[i].en, tbl[i].clr, 0);
            do_tick(lat, mix);
            check($sformatf("tbl%0d_latency", i), lat, 6);
            check($sformatf("tbl%0d_mix", i), mix, tbl[i].exp_mix);
        end
        repeat (5) @(negedge clk);
        check("mix_held", mix_out, 52);

        // Single-voice ramp through the triangle peak.
        do_reset();
        cfg_write(0, 'h0100, 1'b1, 1'b0, 0);
        for (int k = 1; k <= 130; k++) begin
            do_tick(lat, mix);
            exp = (k - 1 < 128) ? k - 1 : 255 - (k - 1);
            check($sformatf("ramp%0d", k), mix, exp);
        end

        // Full scale: all four voices at the peak.
        do_reset();
        for (int v = 0; v < NV; v++) cfg_write(v, 'h7F00, 1'b1, 1'b0, 0);
        do_tick(lat, mix);
        check("full_first", mix, 0);
        do_tick(lat, mix);
        check("full_scale", mix, 508);

        // Second tick two cycles into a scan.
        do_reset();
        cfg_write(0, 'h0100, 1'b1, 1'b0, 0);
        sample_tick = 1'b1;
        @(negedge clk);
        sample_tick = 1'b0;
        @(negedge clk);
        sample_tick = 1'b1;
        @(negedge clk);
        sample_tick = 1'b0;
        check("overrun_set", overrun, 1);
        lat = 3;
        wait_valid(lat);
        check("overrun_scan_latency", lat, 6);
        check("overrun_scan_mix", mix_out, 0);
        @(negedge clk);
        check("overrun_no_restart", busy, 0);
        do_tick(lat, mix);
        check("overrun_next_mix", mix, 1);
        check("overrun_sticky", overrun, 1);

        // Tick during DONE is ignored as well.
        do_reset();
        sample_tick = 1'b1;
        @(negedge clk);
        sample_tick = 1'b0;
        lat = 1;
        wait_valid(lat);
        check("done_tick_latency", lat, 6);
        check("done_tick_overrun_before", overrun, 0);
        sample_tick = 1'b1;
        @(negedge clk);
        sample_tick = 1'b0;
        check("done_tick_ignored", busy, 0);
        check("done_tick_overrun", overrun, 1);

        // Phase clear on voice 1 on the edge that captures it.
        do_reset();
        cfg_write(1, 'h0100, 1'b1, 1'b0, 0);
        do_tick(lat, mix);
        check("clr_pre_mix", mix, 0);
        sample_tick = 1'b1;
        @(negedge clk);
        sample_tick = 1'b0;
        @(negedge clk);
        @(negedge clk);
        cfg_we = 1'b1; cfg_addr = 2'd1; cfg_inc = 16'h0100; cfg_en = 1'b1; cfg_phase_clr = 1'b1;
        @(negedge clk);
        cfg_we = 1'b0; cfg_phase_clr = 1'b0;
        lat = 4;
        wait_valid(lat);
        check("clr_scan_latency", lat, 6);
        check("clr_scan_mix", mix_out, 1);
        @(negedge clk);
        do_tick(lat, mix);
        check("clr_after_mix", mix, 0);

        do_reset();
        cfg_write(0, 'h7F00, 1'b1, 1'b0, 0);
        do_tick(lat, mix);
        do_tick(lat, mix);
        check("peak_mix", mix, 127);
`ifdef VOICE_ATTEN_EN
        do_reset();
        cfg_write(0, 'h7F00, 1'b1, 1'b0, 0);
        do_tick(lat, mix);
        cfg_write(0, 'h7F00, 1'b1, 1'b0, 2);
        do_tick(lat, mix);
        check("atten_shift2", mix, 31);
`endif

        // Reset asserted in the middle of a scan.
        sample_tick = 1'b1;
        @(negedge clk);
        sample_tick = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("midreset_busy", busy, 0);
        check("midreset_mix_out", mix_out, 0);
        check("midreset_mix_valid", mix_valid, 0);
        @(negedge clk);
        rst_n = 1'b1;
        cnt = 0;
        repeat (12) begin
            @(negedge clk);
            if (mix_valid) cnt++;
        end
        check("midreset_no_valid", cnt, 0);

        // Randomized configuration against the voice-level model.
        do_reset();
        for (int it = 0; it < 40; it++) begin
            cnt = $urandom_range(0, 2);
            for (int w = 0; w < cnt; w++) begin
                cfg_write($urandom_range(0, NV - 1), $urandom & 16'hFFFF,
                          1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0),
                          $urandom_range(0, 3));
            end
            exp = model_scan();
            do_tick(lat, mix);
            check($sformatf("rand%0d_latency", it), lat, 6);
            check($sformatf("rand%0d_mix", it), mix, exp);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
